alu_meta_v2: RTL

Parametrised successor to the stage metadata-modification ALU in the RMT action engine. Consumes one {metadata, comp_ins} vector plus its action word per transfer, rewrites dst_port / discard / next_table_id fields per opcode, and emits the modified vector two cycles later.
- New versus the previous generation: configurable field positions, two extra opcodes, valid/ready back-pressure, a sticky alignment-error flag and optional saturating statistics.

---
 rtl/alu_meta_pkg.sv | 29 ++
 rtl/alu_meta_sat_cnt.sv | 34 +++
 rtl/alu_meta_v2.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_meta_pkg.sv
// Shared constants for the metadata-modification ALU: opcodes, action-word
// field offsets (measured down from the action MSB) and default widths.
package alu_meta_pkg;

    localparam int DEF_ACTION_LEN  = 25;
    localparam int DEF_META_LEN    = 256;
    localparam int DEF_COMP_LEN    = 100;
    localparam int DEF_PORT_LSB    = 24;
    localparam int DEF_DISCARD_POS = 128;
    localparam int DEF_NTID_W      = 6;
    localparam int DEF_CNT_W       = 32;

    localparam int OPCODE_W = 4;
    localparam int PORT_W   = 8;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_SET_PORT    = 4'b1100;
    localparam opcode_t OP_SET_DISCARD = 4'b1101;
    localparam opcode_t OP_SET_BOTH    = 4'b1110;
    localparam opcode_t OP_LOOP_CHK    = 4'b1010;

    // Offsets of each field's MSB below the action word MSB.
    localparam int ACT_OP_OFF   = 0;
    localparam int ACT_PORT_OFF = 4;
    localparam int ACT_DISC_OFF = 12;
    localparam int ACT_NTID_OFF = 14;

endpackage

// File: rtl/alu_meta_sat_cnt.sv
// Saturating statistics counter; a clear takes priority over an increment.
module alu_meta_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/alu_meta_v2.sv
// Two-stage metadata-modification ALU with valid/ready flow control.
// Optional saturating statistics are enabled by defining ALU_META_V2_STATS_EN.
module alu_meta_v2
    import alu_meta_pkg::*;
#(
    parameter int STAGE       = 0,
    parameter int ACTION_LEN  = DEF_ACTION_LEN,
    parameter int META_LEN    = DEF_META_LEN,
    parameter int COMP_LEN    = DEF_COMP_LEN,
    parameter int PORT_LSB    = DEF_PORT_LSB,
    parameter int DISCARD_POS = DEF_DISCARD_POS,
    parameter int NTID_W      = DEF_NTID_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [META_LEN+COMP_LEN-1:0] comp_meta_data_in,
    input  logic                         comp_meta_data_valid_in,
    input  logic [ACTION_LEN-1:0]        action_in,
    input  logic                         action_valid_in,
    output logic                         ready_out,
    output logic [META_LEN+COMP_LEN-1:0] comp_meta_data_out,
    output logic                         comp_meta_data_valid_out,
    input  logic                         ready_in,
    output logic                         align_err,
    input  logic                         stat_clr,
    output logic [CNT_W-1:0]             stat_pkt_cnt,
    output logic [CNT_W-1:0]             stat_drop_cnt
);

    localparam int VEC_W = META_LEN + COMP_LEN;

    opcode_t           opcode;
    logic [PORT_W-1:0] act_port;
    logic              act_disc;
    logic [NTID_W-1:0] act_ntid;
    logic [PORT_W-1:0] in_port;
    logic [VEC_W-1:0]  alu_result;

    logic              s1_valid_q, s1_valid_d;
    logic [VEC_W-1:0]  s1_data_q, s1_data_d;
    logic              s2_valid_q, s2_valid_d;
    logic [VEC_W-1:0]  s2_data_q, s2_data_d;
    logic              align_err_q, align_err_d;
    logic              accept;
    logic              s2_load;
    logic              out_xfer;

    assign opcode   = action_in[ACTION_LEN-1-ACT_OP_OFF -: OPCODE_W];
    assign act_port = action_in[ACTION_LEN-1-ACT_PORT_OFF -: PORT_W];
    assign act_disc = action_in[ACTION_LEN-1-ACT_DISC_OFF];
    assign act_ntid = action_in[ACTION_LEN-1-ACT_NTID_OFF -: NTID_W];
    assign in_port  = comp_meta_data_in[PORT_LSB +: PORT_W];

    always_comb begin
        alu_result = comp_meta_data_in;
        case (opcode)
            OP_SET_PORT: begin
                alu_result[PORT_LSB +: PORT_W]   = act_port;
                alu_result[VEC_W-1 -: NTID_W]    = act_ntid;
            end
            OP_SET_DISCARD: begin
                alu_result[DISCARD_POS]          = act_disc;
                alu_result[VEC_W-1 -: NTID_W]    = act_ntid;
            end
            OP_SET_BOTH: begin
                alu_result[PORT_LSB +: PORT_W]   = act_port;
                alu_result[DISCARD_POS]          = act_disc;
                alu_result[VEC_W-1 -: NTID_W]    = act_ntid;
            end
            OP_LOOP_CHK: begin
                // Packet would be sent back where it came from: drop it.
                if (in_port == act_port) begin
                    alu_result[DISCARD_POS]      = 1'b1;
                end
                alu_result[VEC_W-1 -: NTID_W]    = act_ntid;
            end
            default: ;
        endcase
    end

    // ready_out is combinational from ready_in so a full pipe can refill on drain.
    assign ready_out = ~s1_valid_q | ~s2_valid_q | ready_in;
    assign accept    = comp_meta_data_valid_in & action_valid_in & ready_out;
    assign s2_load   = ~s2_valid_q | ready_in;
    assign out_xfer  = s2_valid_q & ready_in;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        align_err_d = align_err_q | (ready_out & (comp_meta_data_valid_in ^ action_valid_in));

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
            end
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = alu_result;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            align_err_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            align_err_q <= align_err_d;
        end
    end

    assign comp_meta_data_out       = s2_data_q;
    assign comp_meta_data_valid_out = s2_valid_q;
    assign align_err                = align_err_q;

`ifdef ALU_META_V2_STATS_EN
    alu_meta_sat_cnt #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_xfer),
        .clr (stat_clr),
        .cnt (stat_pkt_cnt)
    );

    alu_meta_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_xfer & s2_data_q[DISCARD_POS]),
        .clr (stat_clr),
        .cnt (stat_drop_cnt)
    );

    logic unused_bits;
    assign unused_bits = ^{action_in, 32'(STAGE)};
`else
    assign stat_pkt_cnt  = '0;
    assign stat_drop_cnt = '0;

    logic unused_bits;
    assign unused_bits = ^{action_in, 32'(STAGE), stat_clr, out_xfer};
`endif

endmodule
